// File: rtl/fpu_share_arbiter.sv
// Round-robin arbiter sharing one pipelined float32 core among NREQ requesters; an in-order tag FIFO routes results back.
// Define FPU_ARB_TIMEOUT_EN to add the err_timeout port and the stalled-core watchdog.

module fpu_share_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned TAG_DEPTH = 8,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          core_a,
    output logic [31:0]          core_b,
    output logic [1:0]           core_op,
    output logic                 core_nd,
    input  logic [31:0]          core_result,
    input  logic                 core_rdy,
    output logic                 res_valid,
    output logic [NREQ-1:0]      res_dst,
    output logic [31:0]          res_data,
    output logic                 busy,
    output logic                 err_spurious
`ifdef FPU_ARB_TIMEOUT_EN
    ,
    output logic                 err_timeout
`endif
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CW = TW + 1;

    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   gidx, cand;
    logic            req_any, fifo_ok, blk, flush, issue, pop;

    logic [PW-1:0]   tag_mem_q [TAG_DEPTH];
    logic [TW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [31:0]     core_a_q, core_b_q;
    logic [1:0]      core_op_q;
    logic            core_nd_q;
    logic            res_valid_q;
    logic [NREQ-1:0] res_dst_q, res_dst_d;
    logic [31:0]     res_data_q;
    logic            spur_q;

    always_comb begin
        req_any = 1'b0;
        gidx    = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'((32'(rr_q) + k) % NREQ);
            if (!req_any && req[cand]) begin
                req_any = 1'b1;
                gidx    = cand;
            end
        end
    end

    assign pop     = core_rdy && (cnt_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO may still accept a grant.
    assign fifo_ok = (cnt_q != CW'(TAG_DEPTH)) || pop;
    assign issue   = rst_n && req_any && fifo_ok && !blk;

    always_comb begin
        gnt = '0;
        if (issue) gnt[gidx] = 1'b1;
    end

    always_comb begin
        rr_d = rr_q;
        if (issue) rr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + TW'(issue);
        rd_ptr_d = rd_ptr_q + TW'(pop);
        cnt_d    = cnt_q + CW'(issue) - CW'(pop);
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
        end
    end

    always_comb begin
        res_dst_d = '0;
        if (pop) res_dst_d[tag_mem_q[rd_ptr_q]] = 1'b1;
    end

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          err_to_q;

    // Fires in the TIMEOUT-th consecutive cycle with tags outstanding and no core_rdy.
    assign flush = (cnt_q != '0) && !core_rdy && (wd_q == WW'(TIMEOUT - 1));
    assign wd_d  = (core_rdy || (cnt_q == '0) || flush) ? '0 : wd_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q     <= '0;
            err_to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (flush) err_to_q <= 1'b1;
        end
    end

    assign err_timeout = err_to_q;
`else
    assign flush = 1'b0;
`endif

    assign blk = flush;

    always_ff @(posedge clk) begin
        if (issue) tag_mem_q[wr_ptr_q] <= gidx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            core_a_q    <= '0;
            core_b_q    <= '0;
            core_op_q   <= '0;
            core_nd_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_dst_q   <= '0;
            res_data_q  <= '0;
            spur_q      <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            core_nd_q   <= issue;
            if (issue) begin
                core_a_q  <= req_a[{gidx, 5'b00000} +: 32];
                core_b_q  <= req_b[{gidx, 5'b00000} +: 32];
                core_op_q <= req_op[{gidx, 1'b0} +: 2];
            end
            res_valid_q <= pop;
            res_dst_q   <= res_dst_d;
            if (pop) res_data_q <= core_result;
            if (core_rdy && (cnt_q == '0)) spur_q <= 1'b1;
        end
    end

    assign core_a       = core_a_q;
    assign core_b       = core_b_q;
    assign core_op      = core_op_q;
    assign core_nd      = core_nd_q;
    assign res_valid    = res_valid_q;
    assign res_dst      = res_dst_q;
    assign res_data     = res_data_q;
    assign busy         = (cnt_q != '0);
    assign err_spurious = spur_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Scoreboard bench for fpu_share_arbiter: reference arbiter model, mock float core, result monitor.
// Define FPU_ARB_TIMEOUT_EN to include the watchdog scenario.

module tb_fpu_share_arbiter;

    localparam int unsigned NREQ      = 4;
    localparam int unsigned TAG_DEPTH = 8;
    localparam int unsigned TIMEOUT   = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [2*NREQ-1:0]   req_op;
    logic [32*NREQ-1:0]  req_a, req_b;
    logic [NREQ-1:0]     gnt;
    logic [31:0]         core_a, core_b;
    logic [1:0]          core_op;
    logic                core_nd;
    logic [31:0]         core_result;
    logic                core_rdy;
    logic                res_valid;
    logic [NREQ-1:0]     res_dst;
    logic [31:0]         res_data;
    logic                busy;
    logic                err_spurious;
`ifdef FPU_ARB_TIMEOUT_EN
    logic                err_timeout;
`endif

    logic                r_req [NREQ];
    logic [1:0]          r_op  [NREQ];
    logic [31:0]         r_a   [NREQ];
    logic [31:0]         r_b   [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req[g]            = r_req[g];
        assign req_op[2*g +: 2]  = r_op[g];
        assign req_a[32*g +: 32] = r_a[g];
        assign req_b[32*g +: 32] = r_b[g];
    end

    always #5 clk = ~clk;

    fpu_share_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .core_a(core_a), .core_b(core_b), .core_op(core_op), .core_nd(core_nd),
        .core_result(core_result), .core_rdy(core_rdy), .res_valid(res_valid), .res_dst(res_dst),
        .res_data(res_data), .busy(busy), .err_spurious(err_spurious)
`ifdef FPU_ARB_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    typedef struct { logic [NREQ-1:0] dst; logic [31:0] data; } res_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] op; } iss_t;
    typedef struct { logic [31:0] v; int unsigned t; } core_t;

    res_t  exp_q [$];
    iss_t  iss_q [$];
    core_t core_q[$];

    int unsigned     n_checks = 0, n_fail = 0, cyc = 0;
    bit              model_en = 1'b0, mock_en = 1'b1, stall = 1'b0, rand_lat = 1'b0;
    int unsigned     m_rr = 0, m_occ = 0, m_wd = 0;
    bit              m_spur = 1'b0, m_to = 1'b0;
    logic [31:0]     last_data = '0;
    logic [NREQ-1:0] gnt_seen = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return r2f(f2r(a) + f2r(b));
            2'b01:   return r2f(f2r(a) - f2r(b));
            2'b10:   return r2f(f2r(a) * f2r(b));
            default: return r2f(f2r(a) / f2r(b));
        endcase
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'(120 + $urandom_range(0, 14)), 23'($urandom)};
    endfunction

    task automatic new_op(input int i);
        r_op[i] = 2'($urandom);
        r_a[i]  = rnd_f();
        r_b[i]  = rnd_f();
    endtask

    // Reference arbiter: expected grant per cycle and the result each grant must produce.
    always @(negedge clk) begin
        bit pop, fire;
        logic [NREQ-1:0] eg;
        int unsigned gi, occ0;
        if (model_en) begin
            check("busy", busy, m_occ != 0);
            check("err_spurious", err_spurious, m_spur);
`ifdef FPU_ARB_TIMEOUT_EN
            check("err_timeout", err_timeout, m_to);
`endif
            pop  = core_rdy && (m_occ != 0);
            fire = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            fire = (m_occ != 0) && !core_rdy && (m_wd == TIMEOUT - 1);
`endif
            eg = '0;
            gi = 0;
            if ((m_occ < TAG_DEPTH || pop) && !fire) begin
                for (int k = 0; k < NREQ; k++) begin
                    int unsigned i;
                    i = (m_rr + k) % NREQ;
                    if (eg == '0 && r_req[i]) begin
                        eg = NREQ'(1) << i;
                        gi = i;
                    end
                end
            end
            check("gnt", gnt, eg);
            gnt_seen = gnt;
            if (eg != '0) begin
                exp_q.push_back('{eg, fpu_ref(r_op[gi], r_a[gi], r_b[gi])});
                iss_q.push_back('{r_a[gi], r_b[gi], r_op[gi]});
                m_rr = (gi + 1) % NREQ;
            end
            if (core_rdy && m_occ == 0) m_spur = 1'b1;
            occ0  = m_occ;
            m_occ = m_occ + ((eg != '0) ? 1 : 0) - (pop ? 1 : 0);
            if (fire) begin
                m_occ = 0;
                exp_q.delete();
                m_to  = 1'b1;
                m_wd  = 0;
            end else if (core_rdy || occ0 == 0) begin
                m_wd = 0;
            end else begin
                m_wd++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an issue or a result.
    always @(negedge clk) begin
        iss_t ie;
        res_t re;
        if (model_en) begin
            if (core_nd) begin
                if (iss_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL core_nd: pulse with no pending grant (cycle %0d)", cyc);
                end else begin
                    ie = iss_q.pop_front();
                    check("core_a", core_a, ie.a);
                    check("core_b", core_b, ie.b);
                    check("core_op", core_op, ie.op);
                end
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL res_valid: result with no outstanding op (cycle %0d)", cyc);
                end else begin
                    re = exp_q.pop_front();
                    check("res_dst", res_dst, re.dst);
                    check("res_data", res_data, re.data);
                    last_data = re.data;
                end
            end else begin
                check("res_dst idle", res_dst, '0);
                check("res_data hold", res_data, last_data);
            end
        end
    end

    // Mock pipelined core: in-order results, fixed latency 6 or random, optional stall.
    always @(negedge clk) begin
        if (rst_n && core_nd)
            core_q.push_back('{fpu_ref(core_op, core_a, core_b), cyc + (rand_lat ? $urandom_range(1, 12) : 6)});
    end

    always @(posedge clk) begin
        cyc++;
        #2;
        if (mock_en) begin
            core_rdy = 1'b0;
            if (!stall && core_q.size() > 0 && core_q[0].t <= cyc) begin
                core_rdy    = 1'b1;
                core_result = core_q[0].v;
                void'(core_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        while (n < 400 && !(m_occ == 0 && core_q.size() == 0 && iss_q.size() == 0 && exp_q.size() == 0)) begin
            @(negedge clk);
            n++;
        end
        check("drain within bound", n < 400, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int unsigned n, ng;
        bit found;
        rst_n       = 1'b0;
        core_rdy    = 1'b0;
        core_result = '0;
        for (int i = 0; i < NREQ; i++) begin
            r_req[i] = 1'b1;
            new_op(i);
        end

        // T1: reset with all requests high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("T1 gnt", gnt, '0);
        check("T1 core_nd", core_nd, 1'b0);
        check("T1 core_a", core_a, '0);
        check("T1 core_b", core_b, '0);
        check("T1 core_op", core_op, '0);
        check("T1 res_valid", res_valid, 1'b0);
        check("T1 res_dst", res_dst, '0);
        check("T1 res_data", res_data, '0);
        check("T1 busy", busy, 1'b0);
        check("T1 err_spurious", err_spurious, 1'b0);
`ifdef FPU_ARB_TIMEOUT_EN
        check("T1 err_timeout", err_timeout, 1'b0);
`endif
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
        rst_n    = 1'b1;
        model_en = 1'b1;

        // T2: single 2.0*3.0 from requester 2, core latency 6
        @(posedge clk); #1;
        r_req[2] = 1'b1; r_op[2] = 2'b10; r_a[2] = 32'h4000_0000; r_b[2] = 32'h4040_0000;
        @(negedge clk);
        check("T2 gnt", gnt, 4'b0100);
        @(posedge clk); #1;
        r_req[2] = 1'b0;
        @(negedge clk);
        check("T2 core_nd", core_nd, 1'b1);
        n = 1;
        while (!res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("T2 result cycle after issue", n, 8);
        check("T2 res_dst", res_dst, 4'b0100);
        check("T2 res_data", res_data, 32'h40C0_0000);
        wait_idle();

        // T3: all four held; pointer sits at 3 after T2
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            r_req[i] = 1'b1;
            new_op(i);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("T3 rotation", gnt, NREQ'(1) << ((3 + c) % NREQ));
        end
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
        wait_idle();

        // T4: stalled core fills the tag FIFO, then a pop lets a grant through
        stall = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            r_req[i] = 1'b1;
            new_op(i);
        end
        ng = 0;
        repeat (14) begin
            @(negedge clk);
            if (gnt != '0) ng++;
        end
        check("T4 grants while stalled", ng, TAG_DEPTH);
        check("T4 busy when full", busy, 1'b1);
        stall = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (core_rdy) begin
                found = 1'b1;
                check("T4 grant on pop cycle", gnt != '0, 1'b1);
            end
        end
        check("T4 core_rdy seen", found, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
        wait_idle();

        // T5: core_rdy with nothing outstanding
        mock_en = 1'b0;
        @(posedge clk); #1;
        core_rdy    = 1'b1;
        core_result = $urandom;
        @(posedge clk); #1;
        core_rdy = 1'b0;
        @(negedge clk);
        check("T5 err_spurious", err_spurious, 1'b1);
        check("T5 res_valid", res_valid, 1'b0);
        mock_en = 1'b1;

        // Random traffic with random latency and stalls
        rand_lat = 1'b1;
        repeat (1500) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!r_req[i] || gnt_seen[i]) begin
                    r_req[i] = 1'($urandom_range(0, 1));
                    new_op(i);
                end
            end
            stall = ($urandom_range(0, 99) < 12);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
        stall = 1'b0;
        wait_idle();

`ifdef FPU_ARB_TIMEOUT_EN
        // T6: three ops into a core that never answers
        rand_lat = 1'b0;
        stall    = 1'b1;
        @(posedge clk); #1;
        r_req[0] = 1'b1;
        new_op(0);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        r_req[0] = 1'b0;
        n = 0;
        while (!err_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("T6 err_timeout", err_timeout, 1'b1);
        check("T6 busy after flush", busy, 1'b0);
        core_q.delete();
        stall = 1'b0;
        @(posedge clk); #1;
        r_req[1] = 1'b1;
        new_op(1);
        @(negedge clk);
        check("T6 grant after flush", gnt, 4'b0010);
        @(posedge clk); #1;
        r_req[1] = 1'b0;
        wait_idle();
`endif

        check("leftover expected results", exp_q.size(), 0);
        check("leftover expected issues", iss_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
